// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bus bundle for the round-robin arbiter.
// A single definition serves both sides of the arbiter:
// - Master side: instantiate with NUM_MASTERS set to the number of requesters.
// - Slave side: instantiate with NUM_MASTERS set to 1.
// The arbiter connects to the master side through the slave modport, and to the
// shared slave through the master modport.
interface wb_rr_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0]              cyc;
  logic [NUM_MASTERS-1:0]              stb;
  logic [NUM_MASTERS-1:0]              we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   adr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]   mosi;
  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] sel;
  logic [DATA_WIDTH-1:0]               miso;
  logic [NUM_MASTERS-1:0]              ack;
  logic [NUM_MASTERS-1:0]              err;

  modport master (
    output cyc, stb, we, adr, mosi, sel,
    input  miso, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, mosi, sel,
    output miso, ack, err
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave among NUM_MASTERS masters.
// Behaviour:
// - A grant is held for the whole cyc period of the granted master.
// - The slave response is routed only to the granted master.
// - A strobe left unanswered for TIMEOUT cycles is terminated locally with err.
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic           sys_clk,
  input logic           sys_rst,
  wb_rr_arbiter_if.slave  m_bus,
  wb_rr_arbiter_if.master s_bus
);

  localparam int unsigned SelWidth = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [15:0] CntLimit = 16'(TIMEOUT - 1);

  typedef enum logic {StIdle, StGranted} state_e;

  state_e          r_state;
  logic [IdxW-1:0] r_grant;
  logic [IdxW-1:0] r_last;
  logic [15:0]     r_cnt;

  logic            w_found;
  logic [IdxW-1:0] w_next;
  int unsigned     w_idx;
  logic            w_stb_raw;
  logic            w_timeout;

  // Strobe of the granted master, and the local timeout pulse (an ack or err wins).
  assign w_stb_raw = (r_state == StGranted) & m_bus.stb[r_grant];
  assign w_timeout = w_stb_raw & ~s_bus.ack[0] & ~s_bus.err[0] & (r_cnt == CntLimit);

  // Pick the first requester scanning upward from last+1, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_next  = r_last;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      w_idx = (32'(r_last) + k) % NUM_MASTERS;
      if (!w_found && m_bus.cyc[w_idx]) begin
        w_found = 1'b1;
        w_next  = IdxW'(w_idx);
      end
    end
  end

  // Bus routing: zeros while idle, slice of the granted master otherwise.
  always_comb begin
    s_bus.cyc  = '0;
    s_bus.stb  = '0;
    s_bus.we   = '0;
    s_bus.adr  = '0;
    s_bus.mosi = '0;
    s_bus.sel  = '0;
    m_bus.ack  = '0;
    m_bus.err  = '0;
    m_bus.miso = s_bus.miso;
    if (r_state == StGranted) begin
      s_bus.cyc[0]         = m_bus.cyc[r_grant];
      s_bus.stb[0]         = w_stb_raw & ~w_timeout;
      s_bus.we[0]          = m_bus.we[r_grant];
      s_bus.adr            = m_bus.adr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
      s_bus.mosi           = m_bus.mosi[r_grant*DATA_WIDTH +: DATA_WIDTH];
      s_bus.sel            = m_bus.sel[r_grant*SelWidth +: SelWidth];
      m_bus.ack[r_grant]   = s_bus.ack[0];
      m_bus.err[r_grant]   = s_bus.err[0] | w_timeout;
    end
  end

  // Grant FSM, round-robin pointer and timeout counter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_last  <= IdxW'(NUM_MASTERS - 1);
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_found) begin
            r_grant <= w_next;
            r_state <= StGranted;
          end
        end
        StGranted: begin
          if (!w_stb_raw || s_bus.ack[0] || s_bus.err[0] || w_timeout) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
          // Pointer moves on release so the releasing master goes to the back.
          if (!m_bus.cyc[r_grant]) begin
            r_last  <= r_grant;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
